spi_cmd_ctrl: RTL and testbench



---
 rtl/spi_ctrl_pkg.sv | 28 ++
 rtl/spi_ctrl_timeout.sv | 37 +++
 rtl/spi_cmd_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_spi_cmd_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ctrl_pkg.sv
// Shared types and constants for the SPI command sequencer.
// Holds the FSM state encoding, command-byte layout, the fixed MISO
// fill bytes and the default inter-byte timeout.
package spi_ctrl_pkg;

   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned CMD_RD_BIT      = 7;
   localparam int unsigned TIMEOUT_DEFAULT = 50000;

   localparam logic [BYTE_W-1:0] TX_IDLE  = 8'h00;
   localparam logic [BYTE_W-1:0] TX_ABORT = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_WRITE   = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_READ    = 3'd5,
      ST_ABORT   = 3'd6
   } state_t;

   // Command byte direction: 1 = read burst, 0 = write burst.
   function automatic logic is_rd_cmd(input logic [BYTE_W-1:0] cmd);
      return cmd[CMD_RD_BIT];
   endfunction

endpackage

// File: rtl/spi_ctrl_timeout.sv
// Inter-byte watchdog for the SPI command sequencer.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   run         count enable (frame waiting for a byte)
//   clr         restart count (byte received)
//   expired_c   combinational pulse on the TIMEOUT-th idle cycle
module spi_ctrl_timeout
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic expired_c
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // Counter holds at zero whenever the FSM is not waiting for a byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !run || expired_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired_c = run && !clr && (cnt == LAST);

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: turns framed SPI bytes (command, then data) into
// single-cycle register read/write strobes and supplies the MISO byte.
// Ports:
//   clk, rst_n          clock / async active-low reset
//   nss_active          synchronized chip select, 1 = frame in progress
//   rx_valid, rx_byte   received byte strobe and value
//   tx_byte             byte the slave shifts out next
//   reg_wr, reg_rd      one-cycle register strobes (never together)
//   reg_addr, reg_wdata register address / write data
//   reg_rdata           read data, valid one cycle after reg_rd
//   busy                FSM not idle
//   frame_cnt           frames started, wraps
//   err, err_clr        sticky error (address wrap or timeout) and its clear
module spi_cmd_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int unsigned AW      = 7,
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          nss_active,
   input  logic          rx_valid,
   input  logic [7:0]    rx_byte,
   output logic [7:0]    tx_byte,
   output logic          reg_wr,
   output logic          reg_rd,
   output logic [AW-1:0] reg_addr,
   output logic [7:0]    reg_wdata,
   input  logic [7:0]    reg_rdata,
   output logic          busy,
   output logic [7:0]    frame_cnt,
   output logic          err,
   input  logic          err_clr
);

   localparam logic [AW-1:0] ADDR_MAX = '1;

   state_t        state;
   state_t        state_nxt;
   logic          nss_d;
   logic          nss_rise;
   logic          run;
   logic          timeout_hit;
   logic [AW-1:0] addr;
   logic [AW-1:0] addr_nxt;
   logic [7:0]    tx_byte_nxt;
   logic          reg_wr_nxt;
   logic          reg_rd_nxt;
   logic [AW-1:0] reg_addr_nxt;
   logic [7:0]    reg_wdata_nxt;
   logic [7:0]    frame_cnt_nxt;
   logic [7:0]    frame_inc;
   logic          err_set;
   logic          err_nxt;
   logic          busy_nxt;

   assign nss_rise  = nss_active && !nss_d;
   assign frame_inc = frame_cnt + 8'd1;
   assign run       = (state == ST_CMD) || (state == ST_WRITE) || (state == ST_READ);

   spi_ctrl_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .clr       (rx_valid),
      .expired_c (timeout_hit)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state. Chip-select drop always wins and returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (nss_rise) state_nxt = ST_CMD;
         end
         ST_CMD: begin
            if (!nss_active)      state_nxt = ST_IDLE;
            else if (timeout_hit) state_nxt = ST_ABORT;
            else if (rx_valid)    state_nxt = is_rd_cmd(rx_byte) ? ST_RD_REQ : ST_WRITE;
         end
         ST_WRITE: begin
            if (!nss_active)      state_nxt = ST_IDLE;
            else if (timeout_hit) state_nxt = ST_ABORT;
         end
         ST_RD_REQ: begin
            state_nxt = nss_active ? ST_RD_WAIT : ST_IDLE;
         end
         ST_RD_WAIT: begin
            state_nxt = nss_active ? ST_READ : ST_IDLE;
         end
         ST_READ: begin
            if (!nss_active)      state_nxt = ST_IDLE;
            else if (timeout_hit) state_nxt = ST_ABORT;
            else if (rx_valid)    state_nxt = ST_RD_REQ;
         end
         ST_ABORT: begin
            if (!nss_active) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output/datapath next values. Read strobes are launched on the edge that
   // enters RD_REQ so reg_rd is high exactly while the FSM sits in RD_REQ.
   always_comb begin
      addr_nxt      = addr;
      tx_byte_nxt   = tx_byte;
      reg_wr_nxt    = 1'b0;
      reg_rd_nxt    = 1'b0;
      reg_addr_nxt  = reg_addr;
      reg_wdata_nxt = reg_wdata;
      frame_cnt_nxt = frame_cnt;
      err_set       = timeout_hit;
      case (state)
         ST_IDLE: begin
            if (nss_rise) begin
               frame_cnt_nxt = frame_inc;
               tx_byte_nxt   = frame_inc;
            end
         end
         ST_CMD: begin
            if (rx_valid) begin
               addr_nxt = rx_byte[AW-1:0];
               if (is_rd_cmd(rx_byte)) begin
                  if (nss_active) begin
                     reg_rd_nxt   = 1'b1;
                     reg_addr_nxt = rx_byte[AW-1:0];
                  end
               end else begin
                  tx_byte_nxt = TX_IDLE;
               end
            end
         end
         ST_WRITE: begin
            // A byte arriving with the chip-select drop is still written.
            if (rx_valid) begin
               reg_wr_nxt    = 1'b1;
               reg_addr_nxt  = addr;
               reg_wdata_nxt = rx_byte;
               addr_nxt      = addr + AW'(1);
               if (addr == ADDR_MAX) err_set = 1'b1;
            end
         end
         ST_RD_WAIT: begin
            tx_byte_nxt = reg_rdata;
            addr_nxt    = addr + AW'(1);
            if (addr == ADDR_MAX) err_set = 1'b1;
         end
         ST_READ: begin
            // No prefetch for a byte that coincides with the chip-select drop.
            if (rx_valid && nss_active) begin
               reg_rd_nxt   = 1'b1;
               reg_addr_nxt = addr;
            end
         end
         ST_ABORT: begin
            tx_byte_nxt = TX_ABORT;
         end
         default: ;
      endcase
      if (timeout_hit) tx_byte_nxt = TX_ABORT;
      err_nxt  = err_set || (err && !err_clr);
      busy_nxt = (state_nxt != ST_IDLE);
   end

   // Output register. nss_d resets high so a frame already in progress when
   // reset releases is ignored until chip select has been seen low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nss_d     <= 1'b1;
         addr      <= '0;
         tx_byte   <= TX_IDLE;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= 8'h00;
         frame_cnt <= 8'h00;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         nss_d     <= nss_active;
         addr      <= addr_nxt;
         tx_byte   <= tx_byte_nxt;
         reg_wr    <= reg_wr_nxt;
         reg_rd    <= reg_rd_nxt;
         reg_addr  <= reg_addr_nxt;
         reg_wdata <= reg_wdata_nxt;
         frame_cnt <= frame_cnt_nxt;
         err       <= err_nxt;
         busy      <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Self-checking bench for spi_cmd_ctrl: directed frames from the test plan
// followed by randomized frames, checked against a transaction-level model.
module tb_spi_cmd_ctrl;

   localparam int unsigned AW = 7;
   localparam int unsigned TO = 50000;

   logic          clk;
   logic          rst_n;
   logic          nss_active;
   logic          rx_valid;
   logic [7:0]    rx_byte;
   logic [7:0]    tx_byte;
   logic          reg_wr;
   logic          reg_rd;
   logic [AW-1:0] reg_addr;
   logic [7:0]    reg_wdata;
   logic [7:0]    reg_rdata;
   logic          busy;
   logic [7:0]    frame_cnt;
   logic          err;
   logic          err_clr;

   spi_cmd_ctrl #(.AW(AW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .nss_active (nss_active),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .tx_byte    (tx_byte),
      .reg_wr     (reg_wr),
      .reg_rd     (reg_rd),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .busy       (busy),
      .frame_cnt  (frame_cnt),
      .err        (err),
      .err_clr    (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Register file attached to the DUT, with a preload port for the bench.
   logic [7:0] mem [128];
   logic       pre_we;
   logic [6:0] pre_addr;
   logic [7:0] pre_data;

   always @(posedge clk) begin
      if (pre_we)      mem[pre_addr] <= pre_data;
      else if (reg_wr) mem[reg_addr] <= reg_wdata;
      if (reg_rd)      reg_rdata <= mem[reg_addr];
   end

   // Strobe monitor: {is_write, addr, data}.
   logic [15:0] act_q [$];
   int          overlap_cnt = 0;

   always @(negedge clk) begin
      if (reg_wr) act_q.push_back({1'b1, reg_addr, reg_wdata});
      if (reg_rd) act_q.push_back({1'b0, reg_addr, 8'h00});
      if (reg_wr && reg_rd) overlap_cnt++;
   end

   // Reference model state.
   logic [7:0]  ref_mem [128];
   logic [15:0] exp_q [$];
   logic [7:0]  frame_m;
   logic        err_m;
   logic [7:0]  exp_tx;
   logic        m_cmd_pending;
   logic        m_rd;
   logic [6:0]  m_addr;

   int n_cmp = 0;
   int n_bad = 0;
   int byte_idx = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_byte(input logic [7:0] b, input logic drop);
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = b;
      if (drop) nss_active = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   // Advance past one register access in the burst.
   task automatic model_bump();
      if (m_addr == 7'h7F) err_m = 1'b1;
      m_addr = m_addr + 7'd1;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic drop);
      if (m_cmd_pending) begin
         m_cmd_pending = 1'b0;
         m_rd   = b[7];
         m_addr = b[6:0];
         if (!m_rd) begin
            exp_tx = 8'h00;
         end else if (!drop) begin
            exp_q.push_back({1'b0, m_addr, 8'h00});
            exp_tx = ref_mem[m_addr];
            model_bump();
         end
      end else if (!m_rd) begin
         exp_q.push_back({1'b1, m_addr, b});
         ref_mem[m_addr] = b;
         model_bump();
      end else if (!drop) begin
         exp_q.push_back({1'b0, m_addr, 8'h00});
         exp_tx = ref_mem[m_addr];
         model_bump();
      end
   endtask

   task automatic send(input logic [7:0] b, input logic drop, input int gap);
      pulse_byte(b, drop);
      model_byte(b, drop);
      step(gap);
      byte_idx++;
      check($sformatf("tx_byte#%0d", byte_idx), tx_byte, exp_tx);
   endtask

   task automatic start_frame();
      @(negedge clk);
      nss_active    = 1'b1;
      m_cmd_pending = 1'b1;
      frame_m       = frame_m + 8'd1;
      exp_tx        = frame_m;
      step(2);
      check("start_tx", tx_byte, exp_tx);
      check("start_busy", busy, 1);
   endtask

   task automatic compare_strobes(input string tag);
      check({tag, "_strobe_cnt"}, act_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
         check($sformatf("%s_strobe%0d", tag, i), act_q[i], exp_q[i]);
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic end_frame(input string tag);
      if (nss_active) begin
         @(negedge clk);
         nss_active = 1'b0;
      end
      step(3);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_frame_cnt"}, frame_cnt, frame_m);
      check({tag, "_err"}, err, err_m);
      compare_strobes(tag);
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      err_m   = 1'b0;
      check("err_clr", err, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tx"}, tx_byte, 0);
      check({tag, "_wr"}, reg_wr, 0);
      check({tag, "_rd"}, reg_rd, 0);
      check({tag, "_addr"}, reg_addr, 0);
      check({tag, "_wdata"}, reg_wdata, 0);
      check({tag, "_frame_cnt"}, frame_cnt, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      logic [7:0] old_tx;
      rst_n = 1'b0; nss_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; err_clr = 1'b0;
      pre_we = 1'b0; pre_addr = 7'h00; pre_data = 8'h00;
      frame_m = 8'h00; err_m = 1'b0; exp_tx = 8'h00;
      m_cmd_pending = 1'b0; m_rd = 1'b0; m_addr = 7'h00;
      step(3);
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Preload register file and model.
      for (int i = 0; i < 128; i++) begin
         logic [7:0] v;
         v = (i == 16) ? 8'hAB : (i == 17) ? 8'hCD : 8'($urandom);
         @(negedge clk);
         pre_we = 1'b1; pre_addr = 7'(i); pre_data = v;
         ref_mem[i] = v;
      end
      @(negedge clk);
      pre_we = 1'b0;

      // Write burst.
      start_frame();
      send(8'h05, 1'b0, 6);
      send(8'h11, 1'b0, 6);
      send(8'h22, 1'b0, 6);
      end_frame("write");

      // Read burst with exact first-byte latency.
      start_frame();
      old_tx = exp_tx;
      pulse_byte(8'h90, 1'b0);
      model_byte(8'h90, 1'b0);
      step(1);
      check("rd_lat_early", tx_byte, old_tx);
      step(1);
      check("rd_lat_3cyc", tx_byte, 8'hAB);
      step(4);
      send(8'h00, 1'b0, 6);
      check("rd_second", tx_byte, 8'hCD);
      send(8'h00, 1'b0, 6);
      end_frame("read");

      // Address wrap sets err; err_clr clears it.
      start_frame();
      send(8'h7F, 1'b0, 5);
      send(8'hA1, 1'b0, 5);
      send(8'hB2, 1'b0, 5);
      end_frame("wrap");
      clear_err();

      // Chip select drops with the second data byte; stray byte afterwards.
      start_frame();
      send(8'h20, 1'b0, 5);
      send(8'h01, 1'b0, 5);
      send(8'h02, 1'b1, 5);
      check("drop_busy", busy, 0);
      pulse_byte(8'h55, 1'b0);
      step(4);
      end_frame("drop");

      // Inter-byte timeout.
      start_frame();
      send(8'h01, 1'b0, 4);
      step(TO - 20);
      check("to_before_err", err, 0);
      check("to_before_busy", busy, 1);
      step(40);
      err_m  = 1'b1;
      exp_tx = 8'hFF;
      check("to_err", err, 1);
      check("to_tx", tx_byte, 8'hFF);
      pulse_byte(8'h33, 1'b0);
      step(4);
      check("abort_hold_busy", busy, 1);
      check("abort_hold_tx", tx_byte, 8'hFF);
      end_frame("timeout");
      clear_err();

      // Reset asserted while waiting for read data.
      start_frame();
      pulse_byte(8'h90, 1'b0);
      model_byte(8'h90, 1'b0);
      step(1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      frame_m = 8'h00; err_m = 1'b0; exp_tx = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
      step(5);
      pulse_byte(8'h05, 1'b0);
      step(4);
      pulse_byte(8'h11, 1'b0);
      step(4);
      end_frame("post_rst");
      start_frame();
      send(8'h03, 1'b0, 5);
      send(8'h44, 1'b0, 5);
      end_frame("fresh");

      // Randomized frames.
      for (int f = 0; f < 30; f++) begin
         logic [7:0] cmd;
         int         nd;
         logic       drop_last;
         if ($urandom_range(0, 3) == 0) clear_err();
         cmd[7]    = 1'($urandom_range(0, 1));
         cmd[6:0]  = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(120, 127)) : 7'($urandom);
         nd        = int'($urandom_range(1, 4));
         drop_last = 1'($urandom_range(0, 1));
         start_frame();
         send(cmd, 1'b0, int'($urandom_range(4, 10)));
         for (int k = 0; k < nd; k++)
            send(8'($urandom), drop_last && (k == nd - 1), int'($urandom_range(4, 10)));
         end_frame($sformatf("rnd%0d", f));
      end

      check("wr_rd_exclusive", overlap_cnt, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
